// File: rtl/gpr_file_mp_pkg.sv
// Shared definitions for the general-purpose register file and its users
// (difftest, decode).
package gpr_pkg;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } gpr_state_e;

   localparam int ZERO_REG = 0;
   localparam int GPR_XLEN = 64;
   localparam int GPR_NREG = 32;

endpackage

// File: rtl/gpr_file_mp_if.sv
// Port bundle between the pipeline (issue/writeback/difftest) and the register file.
interface gpr_file_mp_if
   import gpr_pkg::*;
#(
   parameter int XLEN = GPR_XLEN,
   parameter int NREG = GPR_NREG,
   parameter int NRD  = 2,
   parameter int NWR  = 1
);
   localparam int AW = $clog2(NREG);

   logic                 init_done;
   logic [NWR-1:0]       wen;
   logic [NWR*AW-1:0]    waddr;
   logic [NWR*XLEN-1:0]  wdata;
   logic [NRD*AW-1:0]    raddr;
   logic [NRD*XLEN-1:0]  rdata;
   logic [NRD-1:0]       rbusy;
   logic                 sb_set;
   logic [AW-1:0]        sb_addr;
   logic [AW-1:0]        dbg_addr;
   logic [XLEN-1:0]      dbg_data;

   modport master (
      input  init_done, rdata, rbusy, dbg_data,
      output wen, waddr, wdata, raddr, sb_set, sb_addr, dbg_addr
   );

   modport slave (
      output init_done, rdata, rbusy, dbg_data,
      input  wen, waddr, wdata, raddr, sb_set, sb_addr, dbg_addr
   );

endinterface

// File: rtl/gpr_file_mp_wsel.sv
// Write-port priority select for one address: the highest-numbered enabled
// port targeting addr_i wins.
module gpr_wsel #(
   parameter int XLEN = 64,
   parameter int AW   = 5,
   parameter int NWR  = 1
) (
   input  logic [AW-1:0]       addr_i,
   input  logic [NWR-1:0]      wvld_i,
   input  logic [NWR*AW-1:0]   waddr_i,
   input  logic [NWR*XLEN-1:0] wdata_i,
   output logic                hit_o,
   output logic [XLEN-1:0]     data_o
);

   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      for (int i = 0; i < NWR; i++) begin
         if (wvld_i[i] && (waddr_i[i*AW +: AW] == addr_i)) begin
            hit_o  = 1'b1;
            data_o = wdata_i[i*XLEN +: XLEN];
         end
      end
   end

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port GPR file with x0 tied to zero, optional write-to-read bypass,
// pending-write scoreboard and a post-reset hardware clear sequence.
module gpr_file_mp
   import gpr_pkg::*;
#(
   parameter int XLEN   = GPR_XLEN,
   parameter int NREG   = GPR_NREG,
   parameter int NRD    = 2,
   parameter int NWR    = 1,
   parameter int BYPASS = 1
) (
   input  logic          clock,
   input  logic          reset,
   gpr_file_mp_if.slave  bus
);

   localparam int AW = $clog2(NREG);
   localparam logic [0:0] S_INIT = INIT;
   localparam logic [0:0] S_RUN  = RUN;
   localparam logic [AW-1:0] ZADDR = AW'(ZERO_REG);

   logic [0:0]      state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [NREG-1:0] busy_q, busy_d;

   // Flat storage array; difftest binds to it directly.
   logic [XLEN-1:0] mem [NREG];

   logic            run;
   logic [NWR-1:0]  wvld;
   logic [NREG-1:0] e_hit;
   logic [XLEN-1:0] e_dat [NREG];
   logic [NRD-1:0]  r_hit;
   logic [XLEN-1:0] r_dat [NRD];

   assign run = (state_q == S_RUN);

   always_comb begin
      wvld = '0;
      for (int i = 0; i < NWR; i++) begin
         wvld[i] = run && bus.wen[i] && (bus.waddr[i*AW +: AW] != ZADDR);
      end
   end

   for (genvar e = 0; e < NREG; e++) begin : g_ent
      gpr_wsel #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_wsel (
         .addr_i  (AW'(e)),
         .wvld_i  (wvld),
         .waddr_i (bus.waddr),
         .wdata_i (bus.wdata),
         .hit_o   (e_hit[e]),
         .data_o  (e_dat[e])
      );
   end

   for (genvar j = 0; j < NRD; j++) begin : g_rd
      gpr_wsel #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_wsel (
         .addr_i  (bus.raddr[j*AW +: AW]),
         .wvld_i  (wvld),
         .waddr_i (bus.waddr),
         .wdata_i (bus.wdata),
         .hit_o   (r_hit[j]),
         .data_o  (r_dat[j])
      );
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      if (!run) begin
         idx_d = idx_q + AW'(1);
         if (idx_q == AW'(NREG-1)) state_d = S_RUN;
      end else begin
         // Clear first so that a same-cycle claim of the same register wins.
         busy_d = busy_q & ~e_hit;
         if (bus.sb_set && (bus.sb_addr != ZADDR)) busy_d[bus.sb_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_INIT;
         idx_q   <= AW'(1);
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
      end
   end

   always_ff @(posedge clock) begin
      mem[0] <= '0;
      for (int e = 1; e < NREG; e++) begin
         if (!run && (idx_q == AW'(e))) mem[e] <= '0;
         else if (e_hit[e])             mem[e] <= e_dat[e];
      end
   end

   logic [NRD*XLEN-1:0] rdata_c;
   logic [NRD-1:0]      rbusy_c;
   logic [AW-1:0]       ra;
   logic                byp;

   always_comb begin
      rdata_c = '0;
      rbusy_c = '0;
      ra      = '0;
      byp     = 1'b0;
      for (int j = 0; j < NRD; j++) begin
         ra  = bus.raddr[j*AW +: AW];
         byp = (BYPASS != 0) && r_hit[j];
         if (run && (ra != ZADDR)) begin
            rdata_c[j*XLEN +: XLEN] = byp ? r_dat[j] : mem[ra];
            rbusy_c[j]              = busy_q[ra] & ~byp;
         end
      end
   end

   assign bus.rdata     = rdata_c;
   assign bus.rbusy     = rbusy_c;
   assign bus.init_done = run;
   assign bus.dbg_data  = (run && (bus.dbg_addr != ZADDR)) ? mem[bus.dbg_addr] : '0;

endmodule
